// File: rtl/arith_mon_pkg.sv
// Shared types for the x/y accumulator-pair monitor: FSM states and error-code layout.
package arith_mon_pkg;

    localparam int ERR_W      = 3;
    localparam int ERR_FORBID = 0;
    localparam int ERR_REL    = 1;
    localparam int ERR_DELTA  = 2;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_FAIL = 2'd2
    } state_e;

endpackage

// File: rtl/arith_pair_rules.sv
// Combinational rule evaluation for one x/y sample against the previous accepted sample.
module arith_pair_rules
    import arith_mon_pkg::*;
#(
    parameter int W        = 8,
    parameter int STEP     = 10,
    parameter int OFFSET   = 5,
    parameter int FORBID_X = 20,
    parameter int FORBID_Y = 0
) (
    input  logic [W-1:0]     in_x_i,
    input  logic [W-1:0]     in_y_i,
    input  logic [W-1:0]     prev_x_i,
    input  logic [W-1:0]     prev_y_i,
    input  logic             in_step_i,
    input  logic             first_i,
    output logic [ERR_W-1:0] hit_o
);

    localparam logic [W-1:0] STEP_C     = W'(STEP);
    localparam logic [W-1:0] OFFSET_C   = W'(OFFSET);
    localparam logic [W-1:0] FORBID_X_C = W'(FORBID_X);
    localparam logic [W-1:0] FORBID_Y_C = W'(FORBID_Y);

    logic [W-1:0] diff_s;
    logic [W-1:0] exp_x_s;
    logic [W-1:0] exp_y_s;

    // All arithmetic stays W bits wide so wrap-around is treated as legal
    always_comb begin
        diff_s  = in_x_i - in_y_i;
        hit_o   = {ERR_W{1'b0}};
        if (in_step_i) begin
            exp_x_s = prev_x_i + STEP_C;
            exp_y_s = prev_y_i + STEP_C;
        end else begin
            exp_x_s = prev_x_i;
            exp_y_s = prev_y_i;
        end
        hit_o[ERR_FORBID] = (in_x_i == FORBID_X_C) && (in_y_i == FORBID_Y_C);
        hit_o[ERR_REL]    = (diff_s != OFFSET_C);
        if (first_i) begin
            hit_o[ERR_DELTA] = 1'b0;
        end else begin
            hit_o[ERR_DELTA] = (in_x_i != exp_x_s) || (in_y_i != exp_y_s);
        end
    end

endmodule

// File: rtl/arith_pair_monitor.sv
// Checker for the stepped x/y accumulator pair: latches the first violation with its
// data and counts accepted step samples.
module arith_pair_monitor
    import arith_mon_pkg::*;
#(
    parameter int W        = 8,
    parameter int STEP     = 10,
    parameter int OFFSET   = 5,
    parameter int FORBID_X = 20,
    parameter int FORBID_Y = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_step,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    output logic             err_valid,
    output logic [ERR_W-1:0] err_code,
    output logic [W-1:0]     err_x,
    output logic [W-1:0]     err_y,
    output logic [CNT_W-1:0] upd_count,
    output logic [1:0]       state_o
);

    state_e           state_q;
    logic [W-1:0]     prev_x_q;
    logic [W-1:0]     prev_y_q;
    logic             err_valid_q;
    logic [ERR_W-1:0] err_code_q;
    logic [W-1:0]     err_x_q;
    logic [W-1:0]     err_y_q;
    logic [CNT_W-1:0] upd_count_q;
    logic [CNT_W-1:0] upd_count_d;
    logic [ERR_W-1:0] hit_s;
    logic             first_s;

    assign first_s = (state_q == ST_INIT);

    arith_pair_rules #(
        .W        (W),
        .STEP     (STEP),
        .OFFSET   (OFFSET),
        .FORBID_X (FORBID_X),
        .FORBID_Y (FORBID_Y)
    ) u_rules (
        .in_x_i    (in_x),
        .in_y_i    (in_y),
        .prev_x_i  (prev_x_q),
        .prev_y_i  (prev_y_q),
        .in_step_i (in_step),
        .first_i   (first_s),
        .hit_o     (hit_s)
    );

    // Saturating next value of the step counter
    always_comb begin
        if (upd_count_q == {CNT_W{1'b1}}) begin
            upd_count_d = upd_count_q;
        end else begin
            upd_count_d = upd_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Monitor FSM with capture registers and step counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            prev_x_q    <= {W{1'b0}};
            prev_y_q    <= {W{1'b0}};
            err_valid_q <= 1'b0;
            err_code_q  <= {ERR_W{1'b0}};
            err_x_q     <= {W{1'b0}};
            err_y_q     <= {W{1'b0}};
            upd_count_q <= {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_INIT, ST_RUN: begin
                    if (in_valid) begin
                        if (|hit_s) begin
                            err_valid_q <= 1'b1;
                            err_code_q  <= hit_s;
                            err_x_q     <= in_x;
                            err_y_q     <= in_y;
                            state_q     <= ST_FAIL;
                        end else begin
                            prev_x_q <= in_x;
                            prev_y_q <= in_y;
                            state_q  <= ST_RUN;
                            if (in_step) begin
                                upd_count_q <= upd_count_d;
                            end else begin
                                upd_count_q <= upd_count_q;
                            end
                        end
                    end else begin
                        state_q <= state_q;
                    end
                end
                ST_FAIL: begin
                    state_q <= ST_FAIL;
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign err_x     = err_x_q;
    assign err_y     = err_y_q;
    assign upd_count = upd_count_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_arith_pair_monitor.sv
// Directed bench for arith_pair_monitor; a second instance with CNT_W=2 covers saturation.
module tb_arith_pair_monitor;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_step;
    logic [7:0]  in_x;
    logic [7:0]  in_y;

    logic        err_valid;
    logic [2:0]  err_code;
    logic [7:0]  err_x;
    logic [7:0]  err_y;
    logic [15:0] upd_count;
    logic [1:0]  state_o;

    logic        s_err_valid;
    logic [2:0]  s_err_code;
    logic [7:0]  s_err_x;
    logic [7:0]  s_err_y;
    logic [1:0]  s_upd_count;
    logic [1:0]  s_state_o;

    int n_checks = 0;
    int n_errors = 0;

    arith_pair_monitor u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_step   (in_step),
        .in_x      (in_x),
        .in_y      (in_y),
        .err_valid (err_valid),
        .err_code  (err_code),
        .err_x     (err_x),
        .err_y     (err_y),
        .upd_count (upd_count),
        .state_o   (state_o)
    );

    arith_pair_monitor #(.CNT_W(2)) u_dut_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_step   (in_step),
        .in_x      (in_x),
        .in_y      (in_y),
        .err_valid (s_err_valid),
        .err_code  (s_err_code),
        .err_x     (s_err_x),
        .err_y     (s_err_y),
        .upd_count (s_upd_count),
        .state_o   (s_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic v, input logic st, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        in_valid = v;
        in_step  = st;
        in_x     = x;
        in_y     = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string pfx);
        check_val({pfx, "_state"}, 32'(state_o), 32'd0);
        check_val({pfx, "_err_valid"}, 32'(err_valid), 32'd0);
        check_val({pfx, "_err_code"}, 32'(err_code), 32'd0);
        check_val({pfx, "_err_x"}, 32'(err_x), 32'd0);
        check_val({pfx, "_err_y"}, 32'(err_y), 32'd0);
        check_val({pfx, "_upd_count"}, 32'(upd_count), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_step  = 1'b0;
        in_x     = 8'd0;
        in_y     = 8'd0;

        do_reset();
        check_reset_state("rst0");

        // First sample in INIT
        send(1'b1, 1'b0, 8'd5, 8'd0);
        check_val("t1_state", 32'(state_o), 32'd1);
        check_val("t1_err_valid", 32'(err_valid), 32'd0);
        check_val("t1_upd", 32'(upd_count), 32'd0);

        // Invalid cycle carrying the forbidden pair must be ignored
        send(1'b0, 1'b1, 8'd20, 8'd0);
        check_val("idle_state", 32'(state_o), 32'd1);
        check_val("idle_err_valid", 32'(err_valid), 32'd0);

        send(1'b1, 1'b1, 8'd15, 8'd10);
        send(1'b1, 1'b1, 8'd25, 8'd20);
        check_val("t2_upd", 32'(upd_count), 32'd2);
        check_val("t2_err_valid", 32'(err_valid), 32'd0);

        send(1'b1, 1'b0, 8'd25, 8'd20);
        check_val("hold_upd", 32'(upd_count), 32'd2);
        check_val("hold_err_valid", 32'(err_valid), 32'd0);

        // Wrap-around step
        do_reset();
        send(1'b1, 1'b0, 8'd250, 8'd245);
        send(1'b1, 1'b1, 8'd4, 8'd255);
        check_val("wrap_upd", 32'(upd_count), 32'd1);
        check_val("wrap_err_valid", 32'(err_valid), 32'd0);
        check_val("wrap_state", 32'(state_o), 32'd1);

        // Delta violation, then FAIL absorbs later samples
        do_reset();
        send(1'b1, 1'b0, 8'd5, 8'd0);
        send(1'b1, 1'b1, 8'd15, 8'd10);
        send(1'b1, 1'b1, 8'd35, 8'd30);
        check_val("delta_err_valid", 32'(err_valid), 32'd1);
        check_val("delta_err_code", 32'(err_code), 32'd4);
        check_val("delta_err_x", 32'(err_x), 32'd35);
        check_val("delta_err_y", 32'(err_y), 32'd30);
        check_val("delta_state", 32'(state_o), 32'd2);
        check_val("delta_upd", 32'(upd_count), 32'd1);
        send(1'b1, 1'b1, 8'd20, 8'd0);
        check_val("absorb_err_code", 32'(err_code), 32'd4);
        check_val("absorb_err_x", 32'(err_x), 32'd35);
        check_val("absorb_upd", 32'(upd_count), 32'd1);
        check_val("absorb_state", 32'(state_o), 32'd2);

        // Relation-only error on the very first sample: no delta in INIT
        do_reset();
        send(1'b1, 1'b1, 8'd6, 8'd0);
        check_val("rel_err_code", 32'(err_code), 32'd2);
        check_val("rel_err_x", 32'(err_x), 32'd6);
        check_val("rel_upd", 32'(upd_count), 32'd0);

        // Forbidden pair hits all three rules
        do_reset();
        send(1'b1, 1'b0, 8'd5, 8'd0);
        send(1'b1, 1'b1, 8'd20, 8'd0);
        check_val("forbid_err_code", 32'(err_code), 32'd7);
        check_val("forbid_err_x", 32'(err_x), 32'd20);
        check_val("forbid_err_y", 32'(err_y), 32'd0);
        check_val("forbid_err_valid", 32'(err_valid), 32'd1);

        // Reset out of FAIL, then saturation on the narrow counter
        do_reset();
        check_reset_state("rst_fail");
        send(1'b1, 1'b0, 8'd5, 8'd0);
        for (int i = 1; i <= 5; i++) begin
            send(1'b1, 1'b1, 8'(5 + 10 * i), 8'(10 * i));
        end
        check_val("sat_upd_wide", 32'(upd_count), 32'd5);
        check_val("sat_upd_narrow", 32'(s_upd_count), 32'd3);
        check_val("sat_err_valid", 32'(s_err_valid), 32'd0);

        // Hold sample whose value moved is a delta violation
        send(1'b1, 1'b0, 8'd56, 8'd51);
        check_val("holdmove_err_code", 32'(err_code), 32'd4);
        check_val("holdmove_err_y", 32'(err_y), 32'd51);
        check_val("holdmove_upd", 32'(upd_count), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
